execute_mul_pipe: RTL and testbench

//  Parametrised pipelined integer multiplier for the Y execute slot; next generation of the fixed 4-stage 32-bit unit.

---
 rtl/exec_pkg.sv | 33 +++
 rtl/mul_pipe_reg.sv | 27 ++
 rtl/execute_mul_pipe.sv | 147 ++++++++++++++
 tb/tb_execute_mul_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared execute-slot definitions: multiply mode encodings, functional-unit codes
// and the control payload that travels alongside each multiplier stage.
package exec_pkg;

    typedef enum logic [1:0] {
        MODE_MUL   = 2'b00,
        MODE_MULU  = 2'b01,
        MODE_MULH  = 2'b10,
        MODE_MULHU = 2'b11
    } mul_mode_e;

    localparam logic [1:0] FU_Y = 2'd3;

    // Widest register index the payload can carry; narrower units zero-pad.
    localparam int REG_W_MAX = 8;

    typedef struct packed {
        logic                 valid;
        mul_mode_e            mode;
        logic                 neg;
        logic                 zero;
        logic [REG_W_MAX-1:0] regdest;
    } stage_ctrl_t;

    function automatic logic mode_is_signed(input mul_mode_e mode);
        return (mode == MODE_MUL) || (mode == MODE_MULH);
    endfunction

    function automatic logic mode_is_high(input mul_mode_e mode);
        return (mode == MODE_MULH) || (mode == MODE_MULHU);
    endfunction

endpackage

// File: rtl/mul_pipe_reg.sv
// One multiplier pipeline stage register: holds while the pipe is stalled and
// clears synchronously on flush or reset.
module mul_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clock_i,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // NOTE: non-blocking assignments for state; clear is checked before enable so
    // a flush or reset lands even in a stalled cycle.
    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/execute_mul_pipe.sv
// Pipelined integer multiplier for the Y execute slot: signed/unsigned, low/high
// product half, writeback backpressure, flush and overflow reporting.
module execute_mul_pipe
    import exec_pkg::*;
#(
    parameter int         DATA_W  = 32,
    parameter int         REG_W   = 5,
    parameter int         STAGES  = 4,
    parameter logic [1:0] UNIT_ID = FU_Y
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        is_functionalunit,
    input  logic [1:0]        is_mode,
    input  logic [DATA_W-1:0] is_rega,
    input  logic [DATA_W-1:0] is_regb,
    input  logic [REG_W-1:0]  is_regdest,
    output logic              is_ready,
    input  logic              flush,
    input  logic              wb_ready,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_regdest,
    output logic              wb_writereg,
    output logic [DATA_W-1:0] wb_wbvalue,
    output logic              wb_overflow,
    output logic              busy
);

    localparam int CTRL_W = $bits(stage_ctrl_t);
    localparam int PAY_W  = CTRL_W + 2 * DATA_W;
    localparam int WB_W   = 3 + REG_W + DATA_W;
    localparam int MID    = STAGES - 2;

    logic stall;
    logic accept;
    logic clear;

    assign stall    = wb_valid && !wb_ready;
    assign is_ready = !stall && !flush;
    assign accept   = (is_functionalunit == UNIT_ID) && is_ready;
    assign clear    = reset || flush;

    // Stage 1: capture operands as magnitudes plus the sign/zero facts the final stage needs.
    mul_mode_e         in_mode;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    stage_ctrl_t       s1_ctrl_d;
    logic [PAY_W-1:0]  s1_q;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        in_mode           = mul_mode_e'(is_mode);
        a_neg             = mode_is_signed(in_mode) && is_rega[DATA_W-1];
        b_neg             = mode_is_signed(in_mode) && is_regb[DATA_W-1];
        a_mag             = a_neg ? -is_rega : is_rega;
        b_mag             = b_neg ? -is_regb : is_regb;
        s1_ctrl_d         = '0;
        s1_ctrl_d.valid   = accept;
        s1_ctrl_d.mode    = in_mode;
        s1_ctrl_d.neg     = a_neg ^ b_neg;
        s1_ctrl_d.zero    = (is_rega == '0) || (is_regb == '0);
        s1_ctrl_d.regdest[REG_W-1:0] = is_regdest;
    end

    mul_pipe_reg #(.W(PAY_W)) u_stage1 (
        .clock_i (clock),
        .clear_i (clear),
        .en_i    (!stall),
        .d_i     ({s1_ctrl_d, a_mag, b_mag}),
        .q_o     (s1_q)
    );

    // Middle stages: the first forms the full unsigned magnitude product, the rest carry it.
    logic [PAY_W-1:0] mid_q [MID];

    for (genvar i = 0; i < MID; i++) begin : g_mid
        logic [PAY_W-1:0] mid_d;

        if (i == 0) begin : g_mult
            logic [2*DATA_W-1:0] prod;
            assign prod  = {{DATA_W{1'b0}}, s1_q[2*DATA_W-1 -: DATA_W]}
                         * {{DATA_W{1'b0}}, s1_q[DATA_W-1:0]};
            assign mid_d = {s1_q[PAY_W-1 -: CTRL_W], prod};
        end else begin : g_pass
            assign mid_d = mid_q[i-1];
        end

        mul_pipe_reg #(.W(PAY_W)) u_stage (
            .clock_i (clock),
            .clear_i (clear),
            .en_i    (!stall),
            .d_i     (mid_d),
            .q_o     (mid_q[i])
        );
    end

    // Final stage: restore the sign, pick the half, flag results that do not fit.
    stage_ctrl_t         fin_ctrl;
    logic [2*DATA_W-1:0] fin_mag;
    logic [2*DATA_W-1:0] fin_prod;
    logic [DATA_W-1:0]   fin_value;
    logic                fin_ovf;
    logic [WB_W-1:0]     wb_d;
    logic [WB_W-1:0]     wb_q;
    logic                unused_regdest;

    always_comb begin
        fin_ctrl  = stage_ctrl_t'(mid_q[MID-1][PAY_W-1 -: CTRL_W]);
        fin_mag   = mid_q[MID-1][2*DATA_W-1:0];
        fin_prod  = (fin_ctrl.neg && !fin_ctrl.zero) ? -fin_mag : fin_mag;
        fin_value = mode_is_high(fin_ctrl.mode) ? fin_prod[2*DATA_W-1:DATA_W]
                                                : fin_prod[DATA_W-1:0];
        fin_ovf   = 1'b0;
        case (fin_ctrl.mode)
            // Signed low half fits only if the bits from DATA_W-1 upward are a pure sign extension.
            MODE_MUL:  fin_ovf = !((&fin_prod[2*DATA_W-1:DATA_W-1]) || !(|fin_prod[2*DATA_W-1:DATA_W-1]));
            MODE_MULU: fin_ovf = |fin_prod[2*DATA_W-1:DATA_W];
            default:   fin_ovf = 1'b0;
        endcase
        wb_d = '0;
        if (fin_ctrl.valid) begin
            wb_d = {1'b1, fin_ctrl.regdest[REG_W-1:0], !fin_ovf, fin_value, fin_ovf};
        end
    end

    assign unused_regdest = ^fin_ctrl.regdest;

    mul_pipe_reg #(.W(WB_W)) u_stage_wb (
        .clock_i (clock),
        .clear_i (clear),
        .en_i    (!stall),
        .d_i     (wb_d),
        .q_o     (wb_q)
    );

    assign {wb_valid, wb_regdest, wb_writereg, wb_wbvalue, wb_overflow} = wb_q;

    always_comb begin
        busy = s1_q[PAY_W-1] | wb_q[WB_W-1];
        for (int i = 0; i < MID; i++) begin
            busy = busy | mid_q[i][PAY_W-1];
        end
    end

endmodule

// File: tb/tb_execute_mul_pipe.sv
// Scoreboard bench for execute_mul_pipe: expected results are computed with plain
// 64-bit arithmetic at issue time and compared by an independent output monitor.
module tb_execute_mul_pipe;
    import exec_pkg::*;

    localparam int STAGES = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  is_functionalunit;
    logic [1:0]  is_mode;
    logic [31:0] is_rega;
    logic [31:0] is_regb;
    logic [4:0]  is_regdest;
    logic        is_ready;
    logic        flush;
    logic        wb_ready;
    logic        wb_valid;
    logic [4:0]  wb_regdest;
    logic        wb_writereg;
    logic [31:0] wb_wbvalue;
    logic        wb_overflow;
    logic        busy;

    execute_mul_pipe #(
        .DATA_W  (32),
        .REG_W   (5),
        .STAGES  (STAGES),
        .UNIT_ID (FU_Y)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .is_functionalunit (is_functionalunit),
        .is_mode           (is_mode),
        .is_rega           (is_rega),
        .is_regb           (is_regb),
        .is_regdest        (is_regdest),
        .is_ready          (is_ready),
        .flush             (flush),
        .wb_ready          (wb_ready),
        .wb_valid          (wb_valid),
        .wb_regdest        (wb_regdest),
        .wb_writereg       (wb_writereg),
        .wb_wbvalue        (wb_wbvalue),
        .wb_overflow       (wb_overflow),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] value;
        logic        ovf;
        int          acc_edge;
        int          stall0;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_edges = 0;
    logic        head_seen = 1'b0;
    int          ret_count = 0;
    logic [4:0]  last_rd;
    logic [31:0] last_value;
    logic        last_ovf;
    logic        last_wr;
    int          ret_edge[$];
    logic [4:0]  ret_rd[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: the mathematical product of the operands, interpreted per mode.
    function automatic exp_t model(input logic [1:0] mode, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd);
        exp_t          e;
        longint        sa = longint'($signed(a));
        longint        sb = longint'($signed(b));
        longint        sp = sa * sb;
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        longint unsigned up = ua * ub;
        e.rd = rd;
        e.acc_edge = cyc + 1;
        e.stall0 = stall_edges;
        case (mode)
            2'b00: begin
                e.value = sp[31:0];
                e.ovf   = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
            end
            2'b01: begin
                e.value = up[31:0];
                e.ovf   = up > 64'h0000_0000_FFFF_FFFF;
            end
            2'b10: begin
                e.value = sp[63:32];
                e.ovf   = 1'b0;
            end
            default: begin
                e.value = up[63:32];
                e.ovf   = 1'b0;
            end
        endcase
        return e;
    endfunction

    task automatic set_inputs(input logic [1:0] fu, input logic [1:0] mode, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input logic fl, input logic wr);
        is_functionalunit = fu;
        is_mode           = mode;
        is_rega           = a;
        is_regb           = b;
        is_regdest        = rd;
        flush             = fl;
        wb_ready          = wr;
    endtask

    task automatic step(input logic [1:0] fu, input logic [1:0] mode, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic fl, input logic wr);
        set_inputs(fu, mode, a, b, rd, fl, wr);
        @(negedge clock);
        #1;
        if (fl) begin
            exp_q.delete();
        end else if (fu == FU_Y && is_ready && !reset) begin
            exp_q.push_back(model(mode, a, b, rd));
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input logic wr);
        for (int i = 0; i < n; i++) step(2'd0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, wr);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            idle(1, 1'b1);
            n++;
        end
        idle(1, 1'b1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        set_inputs(2'd0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        #1;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: checks every presented result against the head of the expected queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset || flush) begin
                head_seen = 1'b0;
            end else if (!wb_valid) begin
                check("idle_outputs_zero", {wb_regdest, wb_writereg, wb_wbvalue, wb_overflow}, 64'h0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_wb_valid", wb_valid, 1'b0);
            end else begin
                e = exp_q[0];
                if (!head_seen) begin
                    check("latency", cyc - e.acc_edge - (stall_edges - e.stall0), STAGES - 1);
                    head_seen = 1'b1;
                end
                check("wb_regdest", wb_regdest, e.rd);
                check("wb_wbvalue", wb_wbvalue, e.value);
                check("wb_overflow", wb_overflow, e.ovf);
                check("wb_writereg", wb_writereg, !e.ovf);
                if (wb_ready) begin
                    void'(exp_q.pop_front());
                    ret_count++;
                    last_rd    = wb_regdest;
                    last_value = wb_wbvalue;
                    last_ovf   = wb_overflow;
                    last_wr    = wb_writereg;
                    ret_edge.push_back(cyc + 1);
                    ret_rd.push_back(wb_regdest);
                    head_seen = 1'b0;
                end
            end
            if (!reset && !flush && wb_valid && !wb_ready) stall_edges++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base_ret;
        int base_idx;
        reset = 1'b1;
        set_inputs(2'd0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("reset_wb_valid", wb_valid, 1'b0);
        check("reset_is_ready", is_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_wb_zero", {wb_regdest, wb_writereg, wb_wbvalue, wb_overflow}, 64'h0);

        // MUL 7 * -3 arrives after STAGES-1 further edges.
        step(FU_Y, MODE_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 1'b0, 1'b1);
        idle(2, 1'b1);
        check("t1_not_yet_valid", wb_valid, 1'b0);
        check("t1_busy", busy, 1'b1);
        idle(1, 1'b1);
        check("t1_valid", wb_valid, 1'b1);
        check("t1_value", wb_wbvalue, 32'hFFFF_FFEB);
        check("t1_writereg", wb_writereg, 1'b1);
        check("t1_overflow", wb_overflow, 1'b0);
        drain(20);

        // Overflow and high-half corner cases.
        step(FU_Y, MODE_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 1'b0, 1'b1);
        drain(20);
        check("t2a_value", last_value, 32'h8000_0000);
        check("t2a_ovf", last_ovf, 1'b1);
        check("t2a_wr", last_wr, 1'b0);
        step(FU_Y, MODE_MUL, 32'h4000_0000, 32'd4, 5'd3, 1'b0, 1'b1);
        drain(20);
        check("t2b_value", last_value, 32'h0);
        check("t2b_ovf", last_ovf, 1'b1);
        step(FU_Y, MODE_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0, 1'b1);
        drain(20);
        check("t3_mulhu", last_value, 32'hFFFF_FFFE);
        step(FU_Y, MODE_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0, 1'b1);
        drain(20);
        check("t3_mulh", last_value, 32'h0);
        step(FU_Y, MODE_MULU, 32'h0001_0000, 32'h0001_0000, 5'd6, 1'b0, 1'b1);
        drain(20);
        check("t3_mulu_ovf", last_ovf, 1'b1);

        // Back-to-back ops with a 3-cycle writeback stall.
        base_ret = ret_count;
        base_idx = ret_edge.size();
        for (int k = 1; k <= 4; k++) begin
            step(FU_Y, MODE_MULU, 32'(k * 3), 32'(k + 10), 5'(k), 1'b0, 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            set_inputs(FU_Y, MODE_MUL, 32'd9, 32'd9, 5'd20, 1'b0, 1'b0);
            #1;
            check("t4_stall_is_ready", is_ready, 1'b0);
            check("t4_stall_wb_valid", wb_valid, 1'b1);
            check("t4_stall_hold_rd", wb_regdest, 5'd1);
            @(posedge clock);
            #1;
        end
        drain(20);
        check("t4_retired", ret_count - base_ret, 4);
        if (ret_edge.size() >= base_idx + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("t4_order", ret_rd[base_idx + k], 5'(k + 1));
                if (k > 0) check("t4_consecutive", ret_edge[base_idx + k] - ret_edge[base_idx + k - 1], 1);
            end
        end

        // Flush with three ops in flight and a fourth presented.
        base_ret = ret_count;
        for (int k = 0; k < 3; k++) begin
            step(FU_Y, MODE_MUL, 32'(k + 2), 32'd5, 5'(k + 10), 1'b0, 1'b1);
        end
        step(FU_Y, MODE_MUL, 32'd8, 32'd8, 5'd13, 1'b1, 1'b1);
        check("t5_wb_valid", wb_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        step(FU_Y, MODE_MUL, 32'd6, 32'd7, 5'd9, 1'b0, 1'b1);
        drain(20);
        check("t5_only_new_retired", ret_count - base_ret, 1);
        check("t5_new_rd", last_rd, 5'd9);
        check("t5_new_value", last_value, 32'd42);

        // Reset with two ops in flight and writeback not ready.
        step(FU_Y, MODE_MUL, 32'd3, 32'd3, 5'd5, 1'b0, 1'b0);
        step(FU_Y, MODE_MUL, 32'd4, 32'd4, 5'd6, 1'b0, 1'b0);
        pulse_reset();
        check("t6_wb_zero", {wb_valid, wb_regdest, wb_writereg, wb_wbvalue, wb_overflow}, 64'h0);
        check("t6_is_ready", is_ready, 1'b1);
        check("t6_busy", busy, 1'b0);

        // Randomised traffic with bubbles, backpressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] fu;
            fu = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : FU_Y;
            step(fu, 2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 5'($urandom()),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
        end
        drain(50);
        check("final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
